pic_nchan: RTL and testbench
============================

# pic_nchan

Parametrised synchronous programmable interrupt controller and the successor to the 8-input PIC_8259A. It supports NUM_IRQ request lines, a 2-bit register address and a 32-bit data path. It provides per-channel IRR/ISR/IMR, edge or level triggering, fully-nested or rotating priority, specific and non-specific EOI, and AEOI. A two-pulse INTA handshake delivers an 8-bit vector to the CPU-side bus interface.

## Interface
- NUM_IRQ, 16, number of request channels (2..32); ID_W = $clog2(NUM_IRQ)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- chip_select  in  1  active-low select
- read_enable  in  1  active-low read strobe; one access per low cycle while chip_select low
- write_enable  in  1  active-low write strobe; one access per low cycle while chip_select low
- addr  in  2  register select
- data_in  in  32  write data
- data_out  out  32  registered read data
- irq  in  NUM_IRQ  request lines, synchronous to clk
- inta  in  1  active-low acknowledge from CPU
- int_out  out  1  interrupt request to CPU
- vector_out  out  8  interrupt vector
- vector_valid  out  1  one-cycle qualifier for vector_out

## Operation
- **Write addr 0 (control).**
  - bit0 = level mode; bit1 = AEOI; bits[15:8] = vector base.
  - Side effects: clears IRR, ISR, IMR and edge history; sets priority pointer to 0; returns FSM to IDLE.
- **Write addr 1.** IMR ← data_in[NUM_IRQ-1:0].
- **Write addr 2 (command).** data_in[7:5] is the opcode, data_in[4:0] is an id.
  - 001: non-specific EOI; clears the highest-priority ISR bit.
  - 011: specific EOI; clears ISR[id].
  - 101: rotating non-specific EOI; clears as 001, then pointer ← cleared id + 1.
  - 110: set priority; pointer ← id + 1, so id becomes lowest priority.
  - Other opcodes are ignored. An id ≥ NUM_IRQ is ignored.
- **Reads.**
  - addr 0 returns IRR; addr 1 returns IMR; addr 2 returns ISR.
  - addr 3 returns {valid, 23'b0, current candidate vector}.
  - Unused upper bits read 0.
- **Triggering.**
  - Edge mode: irq & ~irq_q sets IRR.
  - Level mode: IRR = registered irq.
- **Priority.**
  - Channel `pointer` is highest, wrapping modulo NUM_IRQ.
  - The candidate is the highest-priority bit of IRR & ~IMR.
  - The candidate is valid only if it outranks every ISR bit (fully nested).
- **FSM.**
  - IDLE: on an inta falling edge, latch the candidate, set ISR[cand], clear IRR[cand] (edge mode) → ACK1. If no valid candidate, latch a spurious flag → ACK1.
  - ACK1: on the next inta falling edge, vector_out = base + cand (spurious: base + NUM_IRQ-1, ISR untouched) and vector_valid = 1. If AEOI, clear ISR[cand]. → IDLE.
- **Boundary cases.**
  - A new edge on a channel in the same cycle its IRR bit is cleared leaves IRR set.
  - An EOI in the same cycle as an IDLE-state acknowledge evaluates against the pre-acknowledge ISR; both take effect.
  - A control write mid-handshake aborts it: no vector is emitted.
  - Vector addition wraps mod 256.

## Timing
- Reset values:
  - int_out = 0, data_out = 0, vector_out = 0, vector_valid = 0.
  - IRR = 0, ISR = 0, IMR = all ones, pointer = 0, state = IDLE.
- Edge on irq sampled at edge N: IRR visible after N+1, int_out high after N+2.
- int_out is registered: high in IDLE with a valid candidate, low in ACK1.
- Register writes take effect the cycle after the strobe.
- data_out is updated the cycle after the read strobe and held until the next read.
- vector_valid pulses for exactly one cycle, one cycle after the second inta falling edge.

## Configuration
- PIC_POLL_EN defined: a read of addr 3 also performs a full acknowledge in IDLE (ISR set, IRR cleared, AEOI honoured) and returns the vector with bit31 = valid. FSM state is unchanged.
- PIC_POLL_EN undefined: an addr 3 read has no side effects.

## Structure
- **pic_pkg:** address constants, command opcodes, FSM state enum, SPURIOUS handling constant.
- **pic_priority_resolver:** rotate by pointer, priority-encode, compare against ISR. Produces candidate id, valid flag, and the highest-ISR id used by non-specific EOI.

## Test plan
All scenarios use NUM_IRQ = 16.
- **Basic edge:** control 0x0000A800, IMR 0, pulse irq[3] → int_out high, two inta pulses → vector 0xAB, ISR = 0x0008; specific EOI 0x63 → ISR = 0.
- **Nesting:** ack irq[4]; raise irq[5] then irq[3] → int_out only for 3. Second ack → vector base+3, ISR = 0x0018. Non-specific EOI clears bit 3 first.
- **AEOI plus mask:** control bit1 set, IMR = 0x0001, irq[0] and irq[1] → vector base+1, ISR stays 0, IRR = 0x0001.
- **Rotation:** command 0xC2, so id 2 is lowest. Simultaneous irq[2] and irq[3] → vector base+3 first.
- **Spurious and abort:** inta pulses with no request → vector base+15, ISR unchanged. A control write between the pulses → no vector_valid.
- **Reset mid-ACK1:** all outputs return to their reset values the next cycle; IMR = 0xFFFF.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared constants for the pic_nchan interrupt controller: register map,
// command opcodes, handshake states and vector arithmetic.
package pic_pkg;

  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_IMR  = 2'd1;
  localparam logic [1:0] ADDR_CMD  = 2'd2;
  localparam logic [1:0] ADDR_POLL = 2'd3;

  localparam logic [2:0] OP_NS_EOI  = 3'b001;
  localparam logic [2:0] OP_SP_EOI  = 3'b011;
  localparam logic [2:0] OP_ROT_EOI = 3'b101;
  localparam logic [2:0] OP_SET_PRI = 3'b110;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK1 = 1'b1;

  // A spurious acknowledge reports the last channel's vector.
  function automatic logic [7:0] spurious_ofs(input int num_irq);
    return 8'(num_irq - 1);
  endfunction

  function automatic logic [7:0] pic_vec(input logic [7:0] base, input logic [7:0] ofs);
    return base + ofs;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Rotating priority encoder: picks the highest-priority pending request and
// the highest-priority in-service channel, and applies fully-nested gating.
module pic_priority_resolver
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 16,
  parameter int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] req,
  input  logic [NUM_IRQ-1:0] isr,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    cand_id,
  output logic               cand_valid,
  output logic [ID_W-1:0]    isr_id,
  output logic               isr_any
);

  logic [ID_W:0]   pos;
  logic [ID_W-1:0] idx;
  logic [ID_W:0]   cand_rank;
  logic [ID_W:0]   isr_rank;
  logic            req_any;

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    pos       = '0;
    idx       = '0;
    cand_id   = '0;
    isr_id    = '0;
    req_any   = 1'b0;
    isr_any   = 1'b0;
    cand_rank = (ID_W+1)'(NUM_IRQ);
    isr_rank  = (ID_W+1)'(NUM_IRQ);
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      pos = {1'b0, ptr} + (ID_W+1)'(i);
      if (pos >= (ID_W+1)'(NUM_IRQ)) pos = pos - (ID_W+1)'(NUM_IRQ);
      idx = pos[ID_W-1:0];
      if (req[idx]) begin
        cand_id   = idx;
        cand_rank = (ID_W+1)'(i);
        req_any   = 1'b1;
      end
      if (isr[idx]) begin
        isr_id   = idx;
        isr_rank = (ID_W+1)'(i);
        isr_any  = 1'b1;
      end
    end
    cand_valid = req_any && (cand_rank < isr_rank);
  end

endmodule

// File: rtl/pic_nchan.sv
// NUM_IRQ-channel programmable interrupt controller with INTA vector handshake.
// Define PIC_POLL_EN to make an addr-3 read perform a full poll acknowledge.
module pic_nchan
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               chip_select,
  input  logic               read_enable,
  input  logic               write_enable,
  input  logic [1:0]         addr,
  input  logic [31:0]        data_in,
  output logic [31:0]        data_out,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               inta,
  output logic               int_out,
  output logic [7:0]         vector_out,
  output logic               vector_valid
);

  localparam int ID_W = $clog2(NUM_IRQ);

  logic [NUM_IRQ-1:0] irq_s_q, irq_s_d, irq_h_q, irq_h_d;
  logic [NUM_IRQ-1:0] irr_q, irr_d, isr_q, isr_d, imr_q, imr_d;
  logic [ID_W-1:0]    ptr_q, ptr_d, cand_q, cand_d;
  logic [0:0]         state_q, state_d;
  logic               spur_q, spur_d, level_q, level_d, aeoi_q, aeoi_d;
  logic [7:0]         base_q, base_d, vector_out_q, vector_out_d;
  logic               inta_q, inta_d, int_out_q, int_out_d;
  logic               vector_valid_q, vector_valid_d;
  logic [31:0]        data_out_q, data_out_d;

  logic [NUM_IRQ-1:0] isr_set, isr_clr, irr_clr;
  logic [ID_W-1:0]    cand_id, isr_id, id_idx;
  logic               cand_valid, isr_any;
  logic               wr_stb, rd_stb, ctrl_wr, imr_wr, cmd_wr, inta_fall, id_ok;
  logic [2:0]         opcode;
  logic [4:0]         cmd_id;
  logic               unused_data;

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
    if (id == ID_W'(NUM_IRQ - 1)) return '0;
    return id + ID_W'(1);
  endfunction

  assign wr_stb    = ~chip_select & ~write_enable;
  assign rd_stb    = ~chip_select & ~read_enable;
  assign ctrl_wr   = wr_stb && (addr == ADDR_CTRL);
  assign imr_wr    = wr_stb && (addr == ADDR_IMR);
  assign cmd_wr    = wr_stb && (addr == ADDR_CMD);
  assign inta_fall = inta_q & ~inta;
  assign opcode    = data_in[7:5];
  assign cmd_id    = data_in[4:0];
  assign id_ok     = int'(cmd_id) < NUM_IRQ;
  assign id_idx    = cmd_id[ID_W-1:0];
  assign unused_data = ^data_in;

  pic_priority_resolver #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_resolver (
    .req        (irr_q & ~imr_q),
    .isr        (isr_q),
    .ptr        (ptr_q),
    .cand_id    (cand_id),
    .cand_valid (cand_valid),
    .isr_id     (isr_id),
    .isr_any    (isr_any)
  );

  always_comb begin
    irq_s_d        = irq;
    irq_h_d        = irq_s_q;
    imr_d          = imr_wr ? data_in[NUM_IRQ-1:0] : imr_q;
    ptr_d          = ptr_q;
    cand_d         = cand_q;
    state_d        = state_q;
    spur_d         = spur_q;
    level_d        = level_q;
    aeoi_d         = aeoi_q;
    base_d         = base_q;
    vector_out_d   = vector_out_q;
    vector_valid_d = 1'b0;
    inta_d         = inta;
    data_out_d     = data_out_q;
    isr_set        = '0;
    isr_clr        = '0;
    irr_clr        = '0;

    // EOI commands resolve against the ISR as it stood before any acknowledge.
    if (cmd_wr) begin
      case (opcode)
        OP_NS_EOI:  if (isr_any) isr_clr[isr_id] = 1'b1;
        OP_ROT_EOI: if (isr_any) begin
          isr_clr[isr_id] = 1'b1;
          ptr_d           = next_ptr(isr_id);
        end
        OP_SP_EOI:  if (id_ok) isr_clr[id_idx] = 1'b1;
        OP_SET_PRI: if (id_ok) ptr_d = next_ptr(id_idx);
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE: if (inta_fall) begin
        state_d = ST_ACK1;
        cand_d  = cand_id;
        spur_d  = ~cand_valid;
        if (cand_valid) begin
          isr_set[cand_id] = 1'b1;
          irr_clr[cand_id] = 1'b1;
        end
      end
      ST_ACK1: if (inta_fall) begin
        state_d        = ST_IDLE;
        vector_valid_d = 1'b1;
        vector_out_d   = spur_q ? pic_vec(base_q, spurious_ofs(NUM_IRQ))
                                : pic_vec(base_q, 8'(cand_q));
        if (aeoi_q && !spur_q) isr_clr[cand_q] = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef PIC_POLL_EN
    if (rd_stb && addr == ADDR_POLL && state_q == ST_IDLE && cand_valid && !inta_fall) begin
      irr_clr[cand_id] = 1'b1;
      if (!aeoi_q) isr_set[cand_id] = 1'b1;
    end
`endif

    if (rd_stb) begin
      case (addr)
        ADDR_CTRL: data_out_d = 32'(irr_q);
        ADDR_IMR:  data_out_d = 32'(imr_q);
        ADDR_CMD:  data_out_d = 32'(isr_q);
        default:   data_out_d = {cand_valid, 23'b0, pic_vec(base_q, 8'(cand_id))};
      endcase
    end

    // A new edge wins over a same-cycle acknowledge clear.
    if (level_q) irr_d = irq_s_q;
    else         irr_d = (irr_q & ~irr_clr) | (irq_s_q & ~irq_h_q);
    isr_d     = (isr_q & ~isr_clr) | isr_set;
    int_out_d = (state_d == ST_IDLE) && cand_valid;

    // Control write reinitialises everything and aborts any handshake.
    if (ctrl_wr) begin
      level_d        = data_in[0];
      aeoi_d         = data_in[1];
      base_d         = data_in[15:8];
      irr_d          = '0;
      isr_d          = '0;
      imr_d          = '0;
      irq_h_d        = '0;
      ptr_d          = '0;
      state_d        = ST_IDLE;
      int_out_d      = 1'b0;
      vector_valid_d = 1'b0;
      vector_out_d   = vector_out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_s_q        <= '0;
      irq_h_q        <= '0;
      irr_q          <= '0;
      isr_q          <= '0;
      imr_q          <= '1;
      ptr_q          <= '0;
      cand_q         <= '0;
      state_q        <= ST_IDLE;
      spur_q         <= 1'b0;
      level_q        <= 1'b0;
      aeoi_q         <= 1'b0;
      base_q         <= '0;
      vector_out_q   <= '0;
      vector_valid_q <= 1'b0;
      inta_q         <= 1'b1;
      int_out_q      <= 1'b0;
      data_out_q     <= '0;
    end else begin
      irq_s_q        <= irq_s_d;
      irq_h_q        <= irq_h_d;
      irr_q          <= irr_d;
      isr_q          <= isr_d;
      imr_q          <= imr_d;
      ptr_q          <= ptr_d;
      cand_q         <= cand_d;
      state_q        <= state_d;
      spur_q         <= spur_d;
      level_q        <= level_d;
      aeoi_q         <= aeoi_d;
      base_q         <= base_d;
      vector_out_q   <= vector_out_d;
      vector_valid_q <= vector_valid_d;
      inta_q         <= inta_d;
      int_out_q      <= int_out_d;
      data_out_q     <= data_out_d;
    end
  end

  assign data_out     = data_out_q;
  assign int_out      = int_out_q;
  assign vector_out   = vector_out_q;
  assign vector_valid = vector_valid_q;

endmodule

// File: tb/tb_pic_nchan.sv
// Directed self-checking bench for pic_nchan with NUM_IRQ = 16.
module tb_pic_nchan;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chip_select = 1'b1;
  logic        read_enable = 1'b1;
  logic        write_enable = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic [31:0] data_in = 32'd0;
  logic [31:0] data_out;
  logic [15:0] irq = 16'd0;
  logic        inta = 1'b1;
  logic        int_out;
  logic [7:0]  vector_out;
  logic        vector_valid;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] rdata;

  pic_nchan #(.NUM_IRQ(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .chip_select  (chip_select),
    .read_enable  (read_enable),
    .write_enable (write_enable),
    .addr         (addr),
    .data_in      (data_in),
    .data_out     (data_out),
    .irq          (irq),
    .inta         (inta),
    .int_out      (int_out),
    .vector_out   (vector_out),
    .vector_valid (vector_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chip_select = 1'b0; write_enable = 1'b0; addr = a; data_in = d;
    tick();
    chip_select = 1'b1; write_enable = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    chip_select = 1'b0; read_enable = 1'b0; addr = a;
    tick();
    chip_select = 1'b1; read_enable = 1'b1;
    d = data_out;
  endtask

  task automatic pulse_irq(input logic [15:0] m);
    irq = m;
    tick();
    irq = 16'd0;
    tick();
  endtask

  task automatic inta_low();
    inta = 1'b0;
    tick();
  endtask

  task automatic inta_high();
    inta = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    tick(); tick();
    reset = 1'b0;
    n_cmp++; if (int_out !== 1'b0) begin n_bad++; $display("FAIL rst_int_out got %b want 0", int_out); end
    n_cmp++; if (data_out !== 32'd0) begin n_bad++; $display("FAIL rst_data_out got %h want 0", data_out); end
    n_cmp++; if (vector_valid !== 1'b0) begin n_bad++; $display("FAIL rst_vvalid got %b want 0", vector_valid); end
    rd(2'd1, rdata);
    n_cmp++; if (rdata !== 32'h0000FFFF) begin n_bad++; $display("FAIL rst_imr got %h want 0000ffff", rdata); end
  endtask

  task automatic test_basic_edge();
    wr(2'd0, 32'h0000A800);
    wr(2'd1, 32'h0);
    pulse_irq(16'h0008);
    n_cmp++; if (int_out !== 1'b0) begin n_bad++; $display("FAIL edge_int_early got %b want 0", int_out); end
    tick();
    n_cmp++; if (int_out !== 1'b1) begin n_bad++; $display("FAIL edge_int got %b want 1", int_out); end
    rd(2'd3, rdata);
    n_cmp++; if (rdata !== 32'h800000AB) begin n_bad++; $display("FAIL edge_cand got %h want 800000ab", rdata); end
    inta_low();
    n_cmp++; if (int_out !== 1'b0) begin n_bad++; $display("FAIL edge_int_ack1 got %b want 0", int_out); end
    inta_high(); inta_low();
    n_cmp++; if (vector_valid !== 1'b1 || vector_out !== 8'hAB) begin n_bad++; $display("FAIL edge_vec got %b/%h want 1/ab", vector_valid, vector_out); end
    inta_high();
    n_cmp++; if (vector_valid !== 1'b0) begin n_bad++; $display("FAIL edge_vpulse got %b want 0", vector_valid); end
    rd(2'd2, rdata);
    n_cmp++; if (rdata !== 32'h00000008) begin n_bad++; $display("FAIL edge_isr got %h want 00000008", rdata); end
    wr(2'd2, 32'h63);
    rd(2'd2, rdata);
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL edge_eoi got %h want 0", rdata); end
  endtask

  task automatic test_nesting();
    wr(2'd0, 32'h0000A800);
    pulse_irq(16'h0010); tick();
    inta_low(); inta_high(); inta_low();
    n_cmp++; if (vector_out !== 8'hAC) begin n_bad++; $display("FAIL nest_vec4 got %h want ac", vector_out); end
    inta_high();
    pulse_irq(16'h0020); tick();
    n_cmp++; if (int_out !== 1'b0) begin n_bad++; $display("FAIL nest_block5 got %b want 0", int_out); end
    pulse_irq(16'h0008); tick();
    n_cmp++; if (int_out !== 1'b1) begin n_bad++; $display("FAIL nest_int3 got %b want 1", int_out); end
    inta_low(); inta_high(); inta_low();
    n_cmp++; if (vector_valid !== 1'b1 || vector_out !== 8'hAB) begin n_bad++; $display("FAIL nest_vec3 got %b/%h want 1/ab", vector_valid, vector_out); end
    inta_high();
    rd(2'd2, rdata);
    n_cmp++; if (rdata !== 32'h00000018) begin n_bad++; $display("FAIL nest_isr got %h want 00000018", rdata); end
    rd(2'd0, rdata);
    n_cmp++; if (rdata !== 32'h00000020) begin n_bad++; $display("FAIL nest_irr got %h want 00000020", rdata); end
    wr(2'd2, 32'h20);
    rd(2'd2, rdata);
    n_cmp++; if (rdata !== 32'h00000010) begin n_bad++; $display("FAIL nest_nseoi got %h want 00000010", rdata); end
    wr(2'd2, 32'h20);
    tick();
    n_cmp++; if (int_out !== 1'b1) begin n_bad++; $display("FAIL nest_int5 got %b want 1", int_out); end
  endtask

  task automatic test_aeoi_mask();
    wr(2'd0, 32'h0000A802);
    wr(2'd1, 32'h00000001);
    pulse_irq(16'h0003); tick();
    inta_low(); inta_high(); inta_low();
    n_cmp++; if (vector_valid !== 1'b1 || vector_out !== 8'hA9) begin n_bad++; $display("FAIL aeoi_vec got %b/%h want 1/a9", vector_valid, vector_out); end
    inta_high();
    rd(2'd2, rdata);
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL aeoi_isr got %h want 0", rdata); end
    rd(2'd0, rdata);
    n_cmp++; if (rdata !== 32'h00000001) begin n_bad++; $display("FAIL aeoi_irr got %h want 00000001", rdata); end
  endtask

  task automatic test_rotation();
    wr(2'd0, 32'h0000A800);
    wr(2'd2, 32'hC2);
    pulse_irq(16'h000C); tick();
    inta_low(); inta_high(); inta_low();
    n_cmp++; if (vector_out !== 8'hAB) begin n_bad++; $display("FAIL rot_first got %h want ab", vector_out); end
    inta_high();
    wr(2'd2, 32'h63);
    tick();
    inta_low(); inta_high(); inta_low();
    n_cmp++; if (vector_valid !== 1'b1 || vector_out !== 8'hAA) begin n_bad++; $display("FAIL rot_second got %b/%h want 1/aa", vector_valid, vector_out); end
    inta_high();
    wr(2'd2, 32'hA0);
    rd(2'd2, rdata);
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rot_reoi got %h want 0", rdata); end
  endtask

  task automatic test_spurious_abort();
    wr(2'd0, 32'h0000A800);
    inta_low(); inta_high(); inta_low();
    n_cmp++; if (vector_valid !== 1'b1 || vector_out !== 8'hB7) begin n_bad++; $display("FAIL spur_vec got %b/%h want 1/b7", vector_valid, vector_out); end
    inta_high();
    rd(2'd2, rdata);
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL spur_isr got %h want 0", rdata); end
    inta_low(); inta_high();
    wr(2'd0, 32'h0000A800);
    inta_low();
    n_cmp++; if (vector_valid !== 1'b0) begin n_bad++; $display("FAIL abort_vv got %b want 0", vector_valid); end
    inta_high();
    n_cmp++; if (vector_valid !== 1'b0) begin n_bad++; $display("FAIL abort_vv2 got %b want 0", vector_valid); end
  endtask

  task automatic test_reset_mid_ack();
    wr(2'd0, 32'h0000A800);
    pulse_irq(16'h0008);
    rd(2'd0, rdata);
    n_cmp++; if (rdata !== 32'h00000008) begin n_bad++; $display("FAIL rma_irr got %h want 00000008", rdata); end
    inta_low(); inta_high();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (int_out !== 1'b0 || vector_valid !== 1'b0) begin n_bad++; $display("FAIL rma_ctl got %b/%b want 0/0", int_out, vector_valid); end
    n_cmp++; if (data_out !== 32'd0) begin n_bad++; $display("FAIL rma_data got %h want 0", data_out); end
    n_cmp++; if (vector_out !== 8'd0) begin n_bad++; $display("FAIL rma_vec got %h want 0", vector_out); end
    rd(2'd1, rdata);
    n_cmp++; if (rdata !== 32'h0000FFFF) begin n_bad++; $display("FAIL rma_imr got %h want 0000ffff", rdata); end
    rd(2'd2, rdata);
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rma_isr got %h want 0", rdata); end
    inta_low();
    n_cmp++; if (vector_valid !== 1'b0) begin n_bad++; $display("FAIL rma_idle got %b want 0", vector_valid); end
    inta_high();
  endtask

  initial begin
    test_reset();
    test_basic_edge();
    test_nesting();
    test_aeoi_mask();
    test_rotation();
    test_spurious_abort();
    test_reset_mid_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
